// File: rtl/pipelined_control_unit.sv
// Decode-stage control unit: opcode/mode/cond -> registered ALU command and enables, latency 1.
// Memory ops are held MEM_CYCLES cycles; busy stalls upstream while holding; freeze holds everything.
module pipelined_control_unit #(
    parameter int MODE_LEN            = 2,
    parameter int OPCODE_LEN          = 4,
    parameter int EXECUTE_COMMAND_LEN = 4,
    parameter int MEM_CYCLES          = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [MODE_LEN-1:0]            mode,
    input  logic [OPCODE_LEN-1:0]          opcode,
    input  logic                           s,
    input  logic [3:0]                     cond,
    input  logic [3:0]                     status,
    input  logic                           flush,
    input  logic                           freeze,
    output logic                           out_valid,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic                           wb_en,
    output logic                           branch,
    output logic                           status_update_en,
    output logic [EXECUTE_COMMAND_LEN-1:0] exec_command,
    output logic                           busy
);
    typedef enum logic [0:0] {IDLE, MEM_HOLD} state_t;

    localparam bit         HOLD_EN   = (MEM_CYCLES > 1);
    localparam logic [3:0] HOLD_LOAD = (MEM_CYCLES > 1) ? 4'(MEM_CYCLES - 2) : 4'd0;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic out_valid_q, out_valid_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic wb_en_q, wb_en_d, branch_q, branch_d, status_update_en_q, status_update_en_d;
    logic [EXECUTE_COMMAND_LEN-1:0] exec_command_q, exec_command_d;

    logic cond_pass, n_f, z_f, c_f, v_f;
    logic dec_mr, dec_mw, dec_wb, dec_br, dec_su, is_mem;
    logic [EXECUTE_COMMAND_LEN-1:0] dec_cmd;

    assign {n_f, z_f, c_f, v_f} = status;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f && !z_f;
            4'b1001: cond_pass = !c_f || z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f && (n_f == v_f);
            4'b1101: cond_pass = z_f || (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_wb  = 1'b0;
        dec_br  = 1'b0;
        dec_su  = 1'b0;
        dec_cmd = '0;
        is_mem  = 1'b0;
        if (mode == MODE_LEN'(0)) begin
            dec_wb = 1'b1;
            dec_su = s;
            case (opcode)
                OPCODE_LEN'(4'b1101): dec_cmd = EXECUTE_COMMAND_LEN'(4'b0001);
                OPCODE_LEN'(4'b1111): dec_cmd = EXECUTE_COMMAND_LEN'(4'b1001);
                OPCODE_LEN'(4'b0100): dec_cmd = EXECUTE_COMMAND_LEN'(4'b0010);
                OPCODE_LEN'(4'b0101): dec_cmd = EXECUTE_COMMAND_LEN'(4'b0011);
                OPCODE_LEN'(4'b0010): dec_cmd = EXECUTE_COMMAND_LEN'(4'b0100);
                OPCODE_LEN'(4'b0110): dec_cmd = EXECUTE_COMMAND_LEN'(4'b0101);
                OPCODE_LEN'(4'b0000): dec_cmd = EXECUTE_COMMAND_LEN'(4'b0110);
                OPCODE_LEN'(4'b1100): dec_cmd = EXECUTE_COMMAND_LEN'(4'b0111);
                OPCODE_LEN'(4'b0001): dec_cmd = EXECUTE_COMMAND_LEN'(4'b1000);
                OPCODE_LEN'(4'b1010): begin
                    dec_cmd = EXECUTE_COMMAND_LEN'(4'b0100);
                    dec_wb  = 1'b0;
                    dec_su  = 1'b1;
                end
                OPCODE_LEN'(4'b1000): begin
                    dec_cmd = EXECUTE_COMMAND_LEN'(4'b0110);
                    dec_wb  = 1'b0;
                    dec_su  = 1'b1;
                end
                default: begin
                    dec_wb = 1'b0;
                    dec_su = 1'b0;
                end
            endcase
        end else if (mode == MODE_LEN'(1)) begin
            is_mem  = 1'b1;
            dec_cmd = EXECUTE_COMMAND_LEN'(4'b0010);
            dec_mr  = s;
            dec_wb  = s;
            dec_mw  = !s;
        end else if (mode == MODE_LEN'(2)) begin
            dec_br = 1'b1;
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        out_valid_d        = out_valid_q;
        mem_read_d         = mem_read_q;
        mem_write_d        = mem_write_q;
        wb_en_d            = wb_en_q;
        branch_d           = branch_q;
        status_update_en_d = status_update_en_q;
        exec_command_d     = exec_command_q;
        if (flush) begin
            state_d            = IDLE;
            cnt_d              = 4'd0;
            out_valid_d        = 1'b0;
            mem_read_d         = 1'b0;
            mem_write_d        = 1'b0;
            wb_en_d            = 1'b0;
            branch_d           = 1'b0;
            status_update_en_d = 1'b0;
            exec_command_d     = '0;
        end else if (freeze) begin
            // everything already defaults to its held value
        end else if (state_q == MEM_HOLD) begin
            if (cnt_q == 4'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 4'd1;
        end else begin
            // A failed condition still occupies the slot (out_valid) but does nothing.
            out_valid_d        = in_valid;
            mem_read_d         = in_valid && cond_pass && dec_mr;
            mem_write_d        = in_valid && cond_pass && dec_mw;
            wb_en_d            = in_valid && cond_pass && dec_wb;
            branch_d           = in_valid && cond_pass && dec_br;
            status_update_en_d = in_valid && cond_pass && dec_su;
            exec_command_d     = (in_valid && cond_pass) ? dec_cmd : '0;
            if (HOLD_EN && in_valid && cond_pass && is_mem) begin
                state_d = MEM_HOLD;
                cnt_d   = HOLD_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            cnt_q              <= 4'd0;
            out_valid_q        <= 1'b0;
            mem_read_q         <= 1'b0;
            mem_write_q        <= 1'b0;
            wb_en_q            <= 1'b0;
            branch_q           <= 1'b0;
            status_update_en_q <= 1'b0;
            exec_command_q     <= '0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            out_valid_q        <= out_valid_d;
            mem_read_q         <= mem_read_d;
            mem_write_q        <= mem_write_d;
            wb_en_q            <= wb_en_d;
            branch_q           <= branch_d;
            status_update_en_q <= status_update_en_d;
            exec_command_q     <= exec_command_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign mem_read         = mem_read_q;
    assign mem_write        = mem_write_q;
    assign wb_en            = wb_en_q;
    assign branch           = branch_q;
    assign status_update_en = status_update_en_q;
    assign exec_command     = exec_command_q;
    assign busy             = (state_q == MEM_HOLD);
endmodule
